multi_dart_collision: RTL and testbench
=======================================

Name: multi_dart_collision

Overview:
- Parametrised collision engine between the bloon register file and a bank of N_DARTS independent darts.
- Sweeps the bloon file one index per clock and tests the current bloon against every dart in parallel.
- Keeps a sticky popped mask and drives a per-dart pop-hold state machine that feeds the pop-sprite renderer and dart retirement logic.
- Supersedes the single-dart, externally-indexed collision checker.

Parameters:
N_BLOONS, 32, number of bloon slots in bloonfile (power of two, >=2)
N_DARTS, 4, number of dart slots in dartfile (>=1)
BLOON_SIZE, 32, bloon hit-box edge in pixels
POP_HOLD, 10000000, clocks a dart stays in HOLD after a hit (>=2)
CNT_W, 16, width of pop_count

Ports:
Clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
bloonfile  in  60 x N_BLOONS  bloon records; x=[59:50], y=[29:20]; x==0 or y==0 means empty slot
dartfile  in  20 x N_DARTS  dart positions; x=[19:10], y=[9:0]; all-zero means no dart
clear_popped  in  1  synchronous pulse: clears bloon_popped and pop_count
bloon_popped  out  N_BLOONS  sticky mask, bit i=1 once bloon i is popped
dart_hit  out  N_DARTS  bit d=1 while dart d is in HOLD (dart must be retired)
pop_loc  out  20 x N_DARTS  latched {x,y} of bloon popped by dart d; 0 when idle
pop_event  out  1  one-cycle pulse on every registered pop
pop_count  out  CNT_W  saturating total pops since reset/clear
scan_idx  out  log2(N_BLOONS)  bloon index under test this cycle

Behaviour:
- Reset: asserted asynchronously on reset_n low, released synchronously. While low: scan_idx=0, bloon_popped=0, dart_hit=0, all pop_loc=0, pop_event=0, pop_count=0, all dart FSMs IDLE, hold counters 0. Reset overrides everything, including a HOLD in progress.
- Scan: scan_idx increments every cycle and wraps N_BLOONS-1 -> 0. Each bloon is revisited every N_BLOONS cycles.
- Hit condition for dart d against bloon b=scan_idx, with all comparisons in 11-bit unsigned so bx+BLOON_SIZE-1 cannot wrap:
  - bx<=dx<=bx+BLOON_SIZE-1
  - by<=dy<=by+BLOON_SIZE-1
  - bx!=0, by!=0, dartfile[d]!=0
  - bloon_popped[b]==0
  - dart d is in IDLE
- Arbitration: if several darts hit the same bloon in one cycle, only the lowest-index dart wins. The bloon pops once, and the other darts stay IDLE.
- Latency: a hit detected in cycle t is registered at t+1. At t+1, bloon_popped[b]=1, dart_hit[d]=1, pop_loc[d]={bx,by}, pop_event=1, and pop_count increments.
- Per-dart FSM:
  - IDLE -> HOLD on a winning hit; hold counter loads 0.
  - HOLD increments the counter each cycle.
  - When the counter reaches POP_HOLD-1, the next cycle enters IDLE, clearing dart_hit[d] and pop_loc[d]. dart_hit[d] is therefore high for exactly POP_HOLD cycles.
  - A dart in HOLD is ignored by the detector.
- pop_count saturates at 2^CNT_W-1 and never wraps.
- clear_popped takes effect the next cycle: bloon_popped=0 and pop_count=0. It does not affect dart FSMs or scan_idx. If a pop and clear_popped coincide, the clear wins for the mask and count, but the dart still enters HOLD and pop_event still pulses.
- Empty bloon slots and zero darts never hit. A bloon already popped never re-pops until cleared.
- Outputs are registered with no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle, all inputs 0 -> all outputs 0; scan_idx counts 0..31 and wraps to 0.
- bloon 5 = (x=100,y=200), dart 0 = (115,231) -> one cycle after scan_idx==5: bloon_popped[5]=1, pop_loc[0]=(100,200), pop_event pulses once, pop_count=1. dart_hit[0] stays high for POP_HOLD cycles (bench sets POP_HOLD=8).
- Boundary: dart (132,200) against bloon (100,200) -> no hit. Dart (131,200) -> hit. Bloon x=1000 with dart x=1023 -> hit, proving no 10-bit wrap.
- Darts 1 and 2 both inside bloon 3 in the same cycle -> only dart_hit[1] set, pop_count=1; dart 2 stays IDLE.
- Popped bloon 3 rescanned -> no new pop_event. Pulse clear_popped -> mask 0, count 0; the next scan of bloon 3 pops again.
- reset_n dropped mid-HOLD on dart 0 -> outputs zero immediately, with no clock edge needed. After release, dart 0 is IDLE and scanning restarts at index 0.

Source files
------------

// File: rtl/multi_dart_collision.sv
// rtl/multi_dart_collision.sv - sweeps the bloon file one slot per clock and tests it against every dart
// Keeps a sticky popped mask and a per-dart pop-hold FSM feeding the pop renderer and dart retirement.
module multi_dart_collision #(
  parameter int N_BLOONS   = 32,
  parameter int N_DARTS    = 4,
  parameter int BLOON_SIZE = 32,
  parameter int POP_HOLD   = 10000000,
  parameter int CNT_W      = 16
) (
  input  logic                          Clk,
  input  logic                          reset_n,
  input  logic [60*N_BLOONS-1:0]        bloonfile,
  input  logic [20*N_DARTS-1:0]         dartfile,
  input  logic                          clear_popped,
  output logic [N_BLOONS-1:0]           bloon_popped,
  output logic [N_DARTS-1:0]            dart_hit,
  output logic [20*N_DARTS-1:0]         pop_loc,
  output logic                          pop_event,
  output logic [CNT_W-1:0]              pop_count,
  output logic [$clog2(N_BLOONS)-1:0]   scan_idx
);

  localparam int IDX_W  = $clog2(N_BLOONS);
  localparam int HOLD_W = $clog2(POP_HOLD);

  typedef enum logic {IDLE, HOLD} dart_state_t;

  dart_state_t       state_q [N_DARTS];
  dart_state_t       state_d [N_DARTS];
  logic [HOLD_W-1:0] cnt_q   [N_DARTS];
  logic [HOLD_W-1:0] cnt_d   [N_DARTS];
  logic [19:0]       loc_q   [N_DARTS];
  logic [19:0]       loc_d   [N_DARTS];

  logic [59:0]        bloon;
  logic [10:0]        bx, by, bx_hi, by_hi;
  logic [19:0]        dart;
  logic [10:0]        dx, dy;
  logic               bloon_live;
  logic [N_DARTS-1:0] hit;
  logic [N_DARTS-1:0] win;
  logic               taken;
  logic               any_win;
  logic               unused_bits;

  // Coordinates are widened to 11 bits so the far edge of a bloon near x=1023 does not wrap.
  always_comb begin
    bloon      = bloonfile[int'(scan_idx)*60 +: 60];
    bx         = {1'b0, bloon[59:50]};
    by         = {1'b0, bloon[29:20]};
    bx_hi      = bx + 11'(BLOON_SIZE - 1);
    by_hi      = by + 11'(BLOON_SIZE - 1);
    bloon_live = (bx != 11'd0) && (by != 11'd0) && !bloon_popped[scan_idx];
    dart       = '0;
    dx         = '0;
    dy         = '0;
    hit        = '0;
    for (int d = 0; d < N_DARTS; d++) begin
      dart   = dartfile[d*20 +: 20];
      dx     = {1'b0, dart[19:10]};
      dy     = {1'b0, dart[9:0]};
      hit[d] = (state_q[d] == IDLE) && (dart != 20'd0) && bloon_live &&
               (dx >= bx) && (dx <= bx_hi) && (dy >= by) && (dy <= by_hi);
    end
  end

  assign unused_bits = ^{bloon[49:30], bloon[19:0]};

  // Lowest-index dart wins when several hit the same bloon.
  always_comb begin
    win   = '0;
    taken = 1'b0;
    for (int d = 0; d < N_DARTS; d++) begin
      win[d] = hit[d] && !taken;
      taken  = taken | hit[d];
    end
    any_win = taken;
  end

  always_comb begin
    for (int d = 0; d < N_DARTS; d++) begin
      state_d[d] = state_q[d];
      cnt_d[d]   = cnt_q[d];
      loc_d[d]   = loc_q[d];
      case (state_q[d])
        IDLE: begin
          if (win[d]) begin
            state_d[d] = HOLD;
            cnt_d[d]   = '0;
            loc_d[d]   = {bx[9:0], by[9:0]};
          end
        end
        HOLD: begin
          if (cnt_q[d] == HOLD_W'(POP_HOLD - 1)) begin
            state_d[d] = IDLE;
            cnt_d[d]   = '0;
            loc_d[d]   = '0;
          end else begin
            cnt_d[d] = cnt_q[d] + HOLD_W'(1);
          end
        end
        default: begin
          state_d[d] = IDLE;
          cnt_d[d]   = '0;
          loc_d[d]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx     <= '0;
      bloon_popped <= '0;
      pop_event    <= 1'b0;
      pop_count    <= '0;
      for (int d = 0; d < N_DARTS; d++) begin
        state_q[d] <= IDLE;
        cnt_q[d]   <= '0;
        loc_q[d]   <= '0;
      end
    end else begin
      scan_idx  <= scan_idx + IDX_W'(1);
      pop_event <= any_win;
      // A coincident clear wins over the pop for the mask and count only.
      if (clear_popped) begin
        bloon_popped <= '0;
        pop_count    <= '0;
      end else if (any_win) begin
        bloon_popped[scan_idx] <= 1'b1;
        if (pop_count != {CNT_W{1'b1}}) begin
          pop_count <= pop_count + CNT_W'(1);
        end
      end
      for (int d = 0; d < N_DARTS; d++) begin
        state_q[d] <= state_d[d];
        cnt_q[d]   <= cnt_d[d];
        loc_q[d]   <= loc_d[d];
      end
    end
  end

  always_comb begin
    dart_hit = '0;
    pop_loc  = '0;
    for (int d = 0; d < N_DARTS; d++) begin
      dart_hit[d]         = (state_q[d] == HOLD);
      pop_loc[d*20 +: 20] = loc_q[d];
    end
  end

endmodule

// File: tb/tb_multi_dart_collision.sv
// tb/tb_multi_dart_collision.sv - directed and randomized checks of multi_dart_collision
// Expected values come from constants and a remaining-hold-cycles reference model.
module tb_multi_dart_collision;

  localparam int NB = 32;
  localparam int ND = 4;
  localparam int BS = 32;
  localparam int PH = 8;
  localparam int CW = 4;
  localparam int IW = 5;

  logic              Clk = 1'b0;
  logic              reset_n;
  logic [60*NB-1:0]  bloonfile;
  logic [20*ND-1:0]  dartfile;
  logic              clear_popped;
  logic [NB-1:0]     bloon_popped;
  logic [ND-1:0]     dart_hit;
  logic [20*ND-1:0]  pop_loc;
  logic              pop_event;
  logic [CW-1:0]     pop_count;
  logic [IW-1:0]     scan_idx;

  int total  = 0;
  int passed = 0;

  bit          m_popped [NB];
  int          m_hold   [ND];
  logic [19:0] m_loc    [ND];
  int          m_count;
  int          m_scan;
  bit          m_event;

  multi_dart_collision #(
    .N_BLOONS(NB), .N_DARTS(ND), .BLOON_SIZE(BS), .POP_HOLD(PH), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .bloonfile(bloonfile), .dartfile(dartfile),
    .clear_popped(clear_popped), .bloon_popped(bloon_popped), .dart_hit(dart_hit),
    .pop_loc(pop_loc), .pop_event(pop_event), .pop_count(pop_count), .scan_idx(scan_idx)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int bl_x(int i); return int'(bloonfile[i*60+50 +: 10]); endfunction
  function automatic int bl_y(int i); return int'(bloonfile[i*60+20 +: 10]); endfunction
  function automatic int dt_x(int d); return int'(dartfile[d*20+10 +: 10]); endfunction
  function automatic int dt_y(int d); return int'(dartfile[d*20 +: 10]); endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_popped[i] = 1'b0;
    for (int d = 0; d < ND; d++) begin
      m_hold[d] = 0;
      m_loc[d]  = '0;
    end
    m_count = 0;
    m_scan  = 0;
    m_event = 1'b0;
  endtask

  task automatic model_step();
    int b, bx, by, dx, dy, w;
    b  = m_scan;
    bx = bl_x(b);
    by = bl_y(b);
    w  = -1;
    for (int d = 0; d < ND; d++) begin
      dx = dt_x(d);
      dy = dt_y(d);
      if (w < 0 && m_hold[d] == 0 && (dx != 0 || dy != 0) && bx != 0 && by != 0 &&
          !m_popped[b] && dx >= bx && dx <= bx + BS - 1 && dy >= by && dy <= by + BS - 1)
        w = d;
    end
    for (int d = 0; d < ND; d++) begin
      if (m_hold[d] > 0) begin
        m_hold[d]--;
        if (m_hold[d] == 0) m_loc[d] = '0;
      end
    end
    m_event = (w >= 0);
    if (w >= 0) begin
      m_hold[w] = PH;
      m_loc[w]  = 20'(bx * 1024 + by);
    end
    if (clear_popped) begin
      for (int i = 0; i < NB; i++) m_popped[i] = 1'b0;
      m_count = 0;
    end else if (w >= 0) begin
      m_popped[b] = 1'b1;
      if (m_count < (1 << CW) - 1) m_count++;
    end
    m_scan = (m_scan + 1) % NB;
  endtask

  task automatic tick();
    if (reset_n) model_step();
    else model_reset();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    bloonfile    = '0;
    dartfile     = '0;
    clear_popped = 1'b0;
  endtask

  task automatic set_bloon(int i, int x, int y);
    bloonfile[i*60+50 +: 10] = 10'(x);
    bloonfile[i*60+20 +: 10] = 10'(y);
  endtask

  task automatic set_dart(int d, int x, int y);
    dartfile[d*20 +: 20] = {10'(x), 10'(y)};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    tick();
    tick();
    total++; if (scan_idx !== '0) $display("FAIL reset_scan: got %0d expected 0", scan_idx); else passed++;
    total++; if (bloon_popped !== '0) $display("FAIL reset_popped: got %0h expected 0", bloon_popped); else passed++;
    total++; if (dart_hit !== '0) $display("FAIL reset_hit: got %0h expected 0", dart_hit); else passed++;
    total++; if (pop_loc !== '0) $display("FAIL reset_loc: got %0h expected 0", pop_loc); else passed++;
    total++; if (pop_event !== 1'b0) $display("FAIL reset_event: got %0b expected 0", pop_event); else passed++;
    total++; if (pop_count !== '0) $display("FAIL reset_count: got %0d expected 0", pop_count); else passed++;
    reset_n = 1'b1;
    for (int k = 0; k < 34; k++) begin
      tick();
      total++;
      if (scan_idx !== IW'((k + 1) % NB)) $display("FAIL idle_scan: got %0d expected %0d", scan_idx, (k + 1) % NB);
      else passed++;
      total++;
      if ({bloon_popped, dart_hit, pop_loc, pop_event, pop_count} !== '0)
        $display("FAIL idle_outputs: got nonzero outputs expected all zero");
      else passed++;
    end
  endtask

  task automatic test_single_pop();
    bit found;
    int hcount, events;
    logic [IW-1:0] prev;
    do_reset();
    clear_inputs();
    set_bloon(5, 100, 200);
    set_dart(0, 115, 231);
    found = 1'b0;
    prev  = '0;
    for (int k = 0; k < 64 && !found; k++) begin
      prev = scan_idx;
      tick();
      if (pop_event) found = 1'b1;
    end
    total++; if (!found) $display("FAIL single_timeout: got no pop_event expected one within 64 cycles"); else passed++;
    total++; if (prev !== IW'(5)) $display("FAIL single_latency: got scan %0d expected 5", prev); else passed++;
    total++; if (bloon_popped !== 32'h20) $display("FAIL single_popped: got %0h expected 20", bloon_popped); else passed++;
    total++; if (pop_loc[19:0] !== {10'd100, 10'd200}) $display("FAIL single_loc: got %0h expected %0h", pop_loc[19:0], {10'd100, 10'd200}); else passed++;
    total++; if (pop_count !== CW'(1)) $display("FAIL single_count: got %0d expected 1", pop_count); else passed++;
    total++; if (dart_hit !== 4'b0001) $display("FAIL single_hit: got %0b expected 0001", dart_hit); else passed++;
    hcount = 1;
    events = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dart_hit[0]) hcount++;
      if (pop_event) events++;
    end
    total++; if (hcount != PH) $display("FAIL hold_length: got %0d expected %0d", hcount, PH); else passed++;
    total++; if (events != 1) $display("FAIL single_events: got %0d expected 1", events); else passed++;
    total++; if (pop_loc !== '0) $display("FAIL hold_loc_clear: got %0h expected 0", pop_loc); else passed++;
  endtask

  task automatic test_boundary();
    bit found;
    int events;
    do_reset();
    clear_inputs();
    set_bloon(0, 100, 200);
    set_dart(0, 132, 200);
    events = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (pop_event) events++;
    end
    total++; if (events != 0) $display("FAIL edge_x_outside: got %0d pops expected 0", events); else passed++;
    set_dart(0, 131, 200);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (pop_event) found = 1'b1;
    end
    total++; if (!found) $display("FAIL edge_x_inside: got no pop expected one"); else passed++;
    total++; if (pop_loc[19:0] !== {10'd100, 10'd200}) $display("FAIL edge_loc: got %0h expected %0h", pop_loc[19:0], {10'd100, 10'd200}); else passed++;

    do_reset();
    clear_inputs();
    set_bloon(9, 400, 400);
    set_dart(1, 400, 432);
    events = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (pop_event) events++;
    end
    total++; if (events != 0) $display("FAIL edge_y_outside: got %0d pops expected 0", events); else passed++;

    do_reset();
    clear_inputs();
    set_bloon(7, 1000, 500);
    set_dart(2, 1023, 531);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (pop_event) found = 1'b1;
    end
    total++; if (!found) $display("FAIL nowrap_hit: got no pop expected one"); else passed++;
    total++; if (dart_hit !== 4'b0100) $display("FAIL nowrap_dart: got %0b expected 0100", dart_hit); else passed++;
    total++; if (pop_loc[59:40] !== {10'd1000, 10'd500}) $display("FAIL nowrap_loc: got %0h expected %0h", pop_loc[59:40], {10'd1000, 10'd500}); else passed++;
  endtask

  task automatic test_arbitration_and_clear();
    bit found;
    int events;
    do_reset();
    clear_inputs();
    set_bloon(3, 300, 300);
    set_dart(1, 310, 310);
    set_dart(2, 320, 320);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (pop_event) found = 1'b1;
    end
    total++; if (!found) $display("FAIL arb_timeout: got no pop expected one"); else passed++;
    total++; if (dart_hit !== 4'b0010) $display("FAIL arb_winner: got %0b expected 0010", dart_hit); else passed++;
    total++; if (pop_count !== CW'(1)) $display("FAIL arb_count: got %0d expected 1", pop_count); else passed++;
    total++; if (bloon_popped !== 32'h8) $display("FAIL arb_popped: got %0h expected 8", bloon_popped); else passed++;
    tick();
    total++; if (dart_hit !== 4'b0010) $display("FAIL arb_loser_idle: got %0b expected 0010", dart_hit); else passed++;
    events = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (pop_event) events++;
    end
    total++; if (events != 0) $display("FAIL no_repop: got %0d pops expected 0", events); else passed++;
    clear_popped = 1'b1;
    tick();
    clear_popped = 1'b0;
    total++; if (bloon_popped !== '0) $display("FAIL clear_mask: got %0h expected 0", bloon_popped); else passed++;
    total++; if (pop_count !== '0) $display("FAIL clear_count: got %0d expected 0", pop_count); else passed++;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (pop_event) found = 1'b1;
    end
    total++; if (!found) $display("FAIL repop_timeout: got no pop expected one"); else passed++;
    total++; if (bloon_popped !== 32'h8) $display("FAIL repop_mask: got %0h expected 8", bloon_popped); else passed++;
    total++; if (dart_hit !== 4'b0010) $display("FAIL repop_winner: got %0b expected 0010", dart_hit); else passed++;
  endtask

  task automatic test_clear_coincide();
    int k;
    do_reset();
    clear_inputs();
    set_bloon(3, 50, 60);
    set_dart(0, 60, 70);
    k = 0;
    while (scan_idx !== IW'(3) && k < 40) begin
      tick();
      k++;
    end
    clear_popped = 1'b1;
    tick();
    clear_popped = 1'b0;
    total++; if (pop_event !== 1'b1) $display("FAIL coincide_event: got %0b expected 1", pop_event); else passed++;
    total++; if (dart_hit !== 4'b0001) $display("FAIL coincide_hold: got %0b expected 0001", dart_hit); else passed++;
    total++; if (bloon_popped !== '0) $display("FAIL coincide_mask: got %0h expected 0", bloon_popped); else passed++;
    total++; if (pop_count !== '0) $display("FAIL coincide_count: got %0d expected 0", pop_count); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    clear_inputs();
    for (int i = 0; i < NB; i++) set_bloon(i, 100, 100);
    for (int d = 0; d < ND; d++) set_dart(d, 110 + d, 110 + d);
    for (int k = 0; k < 300; k++) tick();
    total++; if (bloon_popped !== '1) $display("FAIL sat_mask: got %0h expected all ones", bloon_popped); else passed++;
    total++; if (pop_count !== CW'((1 << CW) - 1)) $display("FAIL sat_count: got %0d expected %0d", pop_count, (1 << CW) - 1); else passed++;
  endtask

  function automatic int rand_coord(int span);
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, span)) : 940 + int'($urandom_range(0, span));
  endfunction

  task automatic rand_bloon(int i);
    bloonfile[i*60 +: 60] = 60'({$urandom, $urandom});
    set_bloon(i, rand_coord(80), rand_coord(80));
    if ($urandom_range(0, 9) == 0) bloonfile[i*60+50 +: 10] = '0;
    if ($urandom_range(0, 9) == 0) bloonfile[i*60+20 +: 10] = '0;
  endtask

  task automatic rand_dart(int d);
    if ($urandom_range(0, 9) == 0) set_dart(d, 0, 0);
    else set_dart(d, rand_coord(83), rand_coord(83));
  endtask

  task automatic test_random();
    logic [NB-1:0]    ep;
    logic [ND-1:0]    eh;
    logic [20*ND-1:0] el;
    do_reset();
    clear_inputs();
    for (int i = 0; i < NB; i++) rand_bloon(i);
    for (int d = 0; d < ND; d++) rand_dart(d);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) rand_bloon(int'($urandom_range(0, NB - 1)));
      for (int d = 0; d < ND; d++) if ($urandom_range(0, 3) == 0) rand_dart(d);
      clear_popped = ($urandom_range(0, 39) == 0);
      tick();
      for (int i = 0; i < NB; i++) ep[i] = m_popped[i];
      for (int d = 0; d < ND; d++) begin
        eh[d]           = (m_hold[d] > 0);
        el[d*20 +: 20]  = m_loc[d];
      end
      total++; if (scan_idx !== IW'(m_scan)) $display("FAIL rnd_scan cyc %0d: got %0d expected %0d", k, scan_idx, m_scan); else passed++;
      total++; if (bloon_popped !== ep) $display("FAIL rnd_popped cyc %0d: got %0h expected %0h", k, bloon_popped, ep); else passed++;
      total++; if (dart_hit !== eh) $display("FAIL rnd_hit cyc %0d: got %0b expected %0b", k, dart_hit, eh); else passed++;
      total++; if (pop_loc !== el) $display("FAIL rnd_loc cyc %0d: got %0h expected %0h", k, pop_loc, el); else passed++;
      total++; if (pop_event !== m_event) $display("FAIL rnd_event cyc %0d: got %0b expected %0b", k, pop_event, m_event); else passed++;
      total++; if (pop_count !== CW'(m_count)) $display("FAIL rnd_count cyc %0d: got %0d expected %0d", k, pop_count, m_count); else passed++;
    end
    clear_popped = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    logic [IW-1:0] prev;
    do_reset();
    clear_inputs();
    set_bloon(5, 100, 200);
    set_dart(0, 115, 231);
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      tick();
      if (pop_event) found = 1'b1;
    end
    tick();
    tick();
    total++; if (!found || dart_hit !== 4'b0001) $display("FAIL async_setup: got hit %0b expected 0001", dart_hit); else passed++;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (dart_hit !== '0) $display("FAIL async_hit: got %0b expected 0", dart_hit); else passed++;
    total++; if (pop_loc !== '0) $display("FAIL async_loc: got %0h expected 0", pop_loc); else passed++;
    total++; if (bloon_popped !== '0) $display("FAIL async_popped: got %0h expected 0", bloon_popped); else passed++;
    total++; if (pop_count !== '0) $display("FAIL async_count: got %0d expected 0", pop_count); else passed++;
    total++; if (scan_idx !== '0) $display("FAIL async_scan: got %0d expected 0", scan_idx); else passed++;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (scan_idx !== IW'(1)) $display("FAIL restart_scan: got %0d expected 1", scan_idx); else passed++;
    total++; if (dart_hit !== '0) $display("FAIL restart_idle: got %0b expected 0", dart_hit); else passed++;
    found = 1'b0;
    prev  = '0;
    for (int k = 0; k < 64 && !found; k++) begin
      prev = scan_idx;
      tick();
      if (pop_event) found = 1'b1;
    end
    total++; if (!found || prev !== IW'(5)) $display("FAIL restart_repop: got scan %0d expected pop after 5", prev); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_pop();
    test_boundary();
    test_arbitration_and_clear();
    test_clear_coincide();
    test_saturation();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
